// File: rtl/contrast_range_prep_pkg.sv
// rtl/contrast_range_prep_pkg.sv - shared constants and FSM encoding for contrast_range_prep
package contrast_range_prep_pkg;

  localparam int PIX_W       = 8;
  localparam int DIVD_W      = 16;
  localparam int DIV_LATENCY = 8;
  localparam int FULL_SCALE  = 255;

  localparam logic [PIX_W-1:0] DEFAULT_MIN = 8'd0;
  localparam logic [PIX_W-1:0] DEFAULT_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/contrast_range_prep_valid_delay.sv
// rtl/contrast_range_prep_valid_delay.sv - fixed-depth 1-bit qualifier delay line
// Ports:
//   iclk, irst_n : clock, asynchronous active-low reset (clears every stage)
//   idin         : qualifier in
//   odout        : idin delayed DEPTH cycles
module contrast_range_prep_valid_delay #(
  parameter int DEPTH = 8
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic idin,
  output logic odout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) sr <= '0;
        else         sr <= idin;
      end
    end else begin : g_chain
      always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) sr <= '0;
        else         sr <= {sr[DEPTH-2:0], idin};
      end
    end
  endgenerate

  assign odout = sr[DEPTH-1];

endmodule

// File: rtl/contrast_range_prep.sv
// rtl/contrast_range_prep.sv - per-frame min/max tracking and divider operand generation
// Ports:
//   iclk, irst_n        : clock, asynchronous active-low reset
//   ivalid/isof/ieof    : pixel beat qualifiers (sof/eof only meaningful with ivalid)
//   ipixel              : unsigned pixel
//   odividend/odivisor  : divider operands, 1-cycle latency, held when idle
//   odiv_valid          : operands valid
//   oq_valid            : qualifier aligned with the divider's quotient
//   orange_ok           : a frame range has been committed since reset
//   ocommit             : 1-cycle pulse on range commit
//   omin/omax           : committed range used for mapping
module contrast_range_prep
  import contrast_range_prep_pkg::*;
(
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              ivalid,
  input  logic              isof,
  input  logic              ieof,
  input  logic [PIX_W-1:0]  ipixel,
  output logic [DIVD_W-1:0] odividend,
  output logic [PIX_W-1:0]  odivisor,
  output logic              odiv_valid,
  output logic              oq_valid,
  output logic              orange_ok,
  output logic              ocommit,
  output logic [PIX_W-1:0]  omin,
  output logic [PIX_W-1:0]  omax
);

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   run_min_q, run_min_d;
  logic [PIX_W-1:0]   run_max_q, run_max_d;
  logic               commit_d;

  logic [PIX_W-1:0]   clamped, offset, span;
  logic [DIVD_W-1:0]  scaled;
  logic [DIVD_W-1:0]  dividend_w;
  logic [PIX_W-1:0]   divisor_w;

  // Frame statistics. A sof always restarts the stats (aborting any open
  // frame); an eof closes the frame only if one is open or opens on this beat.
  always_comb begin
    state_d   = state_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    commit_d  = 1'b0;
    if (ivalid) begin
      if (isof) begin
        run_min_d = ipixel;
        run_max_d = ipixel;
        state_d   = ST_ACTIVE;
      end else if (state_q == ST_ACTIVE) begin
        if (ipixel < run_min_q) run_min_d = ipixel;
        if (ipixel > run_max_q) run_max_d = ipixel;
      end
      if (ieof && (isof || (state_q == ST_ACTIVE))) begin
        commit_d = 1'b1;
        state_d  = ST_IDLE;
      end
    end
  end

  // Operands always use the range as it stands before this edge, so the eof
  // pixel is still mapped with the previous frame's range.
  always_comb begin
    clamped = ipixel;
    if (ipixel < omin)      clamped = omin;
    else if (ipixel > omax) clamped = omax;
    offset = clamped - omin;
    span   = omax - omin;
    if (FULL_SCALE == 255) scaled = {offset, 8'h00} - {8'h00, offset};
    else                   scaled = DIVD_W'(offset) * DIVD_W'(FULL_SCALE);
    // A flat range would divide by zero; force quotient 0 instead.
    if (span == '0) begin
      dividend_w = '0;
      divisor_w  = PIX_W'(1);
    end else begin
      dividend_w = scaled;
      divisor_w  = span;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= ST_IDLE;
      run_min_q  <= '0;
      run_max_q  <= '0;
      omin       <= DEFAULT_MIN;
      omax       <= DEFAULT_MAX;
      orange_ok  <= 1'b0;
      ocommit    <= 1'b0;
      odividend  <= '0;
      odivisor   <= PIX_W'(1);
      odiv_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_min_q  <= run_min_d;
      run_max_q  <= run_max_d;
      ocommit    <= commit_d;
      odiv_valid <= ivalid;
      if (commit_d) begin
        omin      <= run_min_d;
        omax      <= run_max_d;
        orange_ok <= 1'b1;
      end
      if (ivalid) begin
        odividend <= dividend_w;
        odivisor  <= divisor_w;
      end
    end
  end

  contrast_range_prep_valid_delay #(
    .DEPTH (DIV_LATENCY)
  ) u_q_valid_delay (
    .iclk   (iclk),
    .irst_n (irst_n),
    .idin   (odiv_valid),
    .odout  (oq_valid)
  );

endmodule
